// File: rtl/starfish_fetch.sv
// Starfish RV32 instruction fetch: owns the PC, issues word reads to a
// one-cycle synchronous imem and buffers {pc, instr} pairs for decode.
module starfish_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic            dbg_state
);

  // Handshake: decode takes the head in any cycle where out_valid && out_ready
  // are both high at the rising edge; out_valid never depends on out_ready.

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   tag;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              inflight;
  logic              kill;
  logic [XLEN-1:0]   buf_instr [DEPTH];
  logic [XLEN-1:0]   buf_pc    [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occ;
  logic [XLEN-1:0]   redirect_aligned;

  assign pop              = out_valid && out_ready;
  assign push             = inflight && !kill;
  // Entries that will be held once this cycle's pop retires: buffered plus in flight.
  assign occ              = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign redirect_aligned = redirect_pc & ~(XLEN'(3));

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN:  issue      = !redirect_valid && (occ < DEPTH_W);
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      tag      <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // Flush wins over any push or pop bookkeeping this cycle.
        pc       <= redirect_aligned;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        inflight <= 1'b0;
        kill     <= 1'b1;
      end else begin
        kill     <= 1'b0;
        inflight <= issue;
        if (issue) begin
          pc  <= pc + XLEN'(4);
          tag <= pc;
        end
        if (push) begin
          buf_instr[wr_ptr] <= imem_rdata;
          buf_pc[wr_ptr]    <= tag;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = buf_instr[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];
  assign dbg_state = (state == RUN);

endmodule

// File: doc/starfish_fetch.md
Name: starfish_fetch

Overview:
- Instruction fetch stage of the Starfish RV32 core; sits directly upstream of decode.
- Owns the PC and issues word reads to the synchronous instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Execute redirects it on taken branches and jumps.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, fetch buffer entries, power of two, >=2.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request, valid this cycle.
- imem_addr  out  XLEN  word-aligned read address; bits [1:0] are always 0.
- imem_rdata  in  XLEN  read data, valid exactly one cycle after an issued request. Memory is always ready.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  XLEN  new fetch address.
- out_valid  out  1  fetch buffer head is valid.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  PC of head instruction.
- out_ready  in  1  decode accepts head this cycle.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, sampled on the clk rising edge.
- Reset values: pc=RESET_PC, state=BOOT, count=0, inflight=0, rd/wr pointers=0, all buffer entries 0.
  - Outputs in reset: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- FSM:
  - BOOT: no request; always moves to RUN next cycle.
  - RUN: normal operation.
  - rst asserted in any state returns to BOOT; any in-flight response is discarded.
- pop = out_valid && out_ready. A pop in a redirect cycle still counts as accepted; decode is responsible for squashing it.
- Issue rule (RUN): imem_req = !redirect_valid && (count + inflight - pop < DEPTH).
  - This path is combinational from out_ready.
  - imem_addr = pc.
  - On issue: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0). inflight <= 1, tag <= pc.
  - Without issue: inflight <= 0.
- Response: when inflight=1 and kill=0, push {tag, imem_rdata} at wr_ptr.
  - The issue rule guarantees the push never overflows.
  - Push and pop in the same cycle are both legal; count is unchanged.
- Redirect (RUN, redirect_valid=1):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - count <= 0 and pointers reset, i.e. the buffer is flushed.
  - The response arriving next cycle (if inflight) is discarded: kill flag set for one cycle.
  - No request is issued this cycle.
  - A redirect has priority over push and pop bookkeeping.
  - A redirect during BOOT is honoured: pc updates, state still goes to RUN.
- Output: out_valid = (count != 0). out_instr and out_pc are driven from the rd_ptr entry, registered storage only.
  - When empty, out_instr and out_pc hold the last head contents and are don't-care.
- Latency:
  - rst deasserted at cycle 0: BOOT at cycle 0, first request at cycle 1, first out_valid at cycle 3.
  - Redirect seen at cycle t: request to new PC at t+1, out_valid with that instruction at t+3.
- Throughput: 1 instruction/cycle sustained when out_ready is held 1 (steady state count=1, inflight=1).
- Backpressure: with out_ready=0, the block stops requesting once count + inflight = DEPTH. No instruction is lost or duplicated.

Test Plan:
1. Reset release with out_ready=1 and imem returning word = addr:
   - imem_req first at cycle 1 (addr 0), then addr 4, 8, 12 on consecutive cycles.
   - out_valid from cycle 3 with out_pc/out_instr = 0, 4, 8, one per cycle.
2. Backpressure: out_ready=0 from the first out_valid for 5 cycles, then 1:
   - Exactly 2 requests are outstanding or buffered; imem_req stays 0 while stalled.
   - On release, the sequence resumes 0, 4, 8, ... with no gap, duplicate or skip.
3. Redirect to 32'h0000_0102 while the buffer is full and a request is in flight:
   - Next request addr 32'h0000_0100.
   - Stale response dropped; out_valid=0 for cycles t+1 and t+2.
   - Next delivered out_pc = 0x100.
4. Simultaneous redirect (target 0x200) and pop:
   - The popped head is delivered once.
   - All other entries flushed; next out_pc = 0x200.
5. PC wrap: redirect to 32'hFFFF_FFF8 with out_ready=1:
   - Delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
6. Mid-operation reset: rst high for 1 cycle during streaming with an in-flight request:
   - All outputs return to reset values the next cycle.
   - Stale response not delivered; fetch restarts at RESET_PC with BOOT timing.
